dpram_access_arbiter: RTL

Single-clock access controller for a dual-port RAM shared by two requesters. Requester 0 drives RAM port A and requester 1 drives RAM port B. On every same-address collision involving a write, the controller grants one requester and stalls the other, so no access is dropped and no write-write or read-write collision reaches the RAM. It sits between the two client engines and the RAM macro, and also returns read data with a valid strobe.

---
 rtl/dpram_access_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/dpram_access_arbiter.sv
// Same-address collision arbiter in front of a dual-port RAM shared by two requesters.
// Build option: define DPRAM_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise requester 0 has fixed priority.
module dpram_access_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  collide_s;
  logic                  prefer1_s;
  logic                  last_winner_r;
  logic                  rsp0_valid_r;
  logic                  rsp1_valid_r;
  logic [DATA_WIDTH-1:0] rdata0_hold_r;
  logic [DATA_WIDTH-1:0] rdata1_hold_r;
  logic [CNT_WIDTH-1:0]  cnt_r;

  // Collision detect and grant selection
  always_comb begin
    collide_s  = 1'b0;
    prefer1_s  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    collide_s  = req0_valid && req1_valid && (req0_addr == req1_addr) && (req0_we || req1_we);
`ifdef DPRAM_ARB_ROUND_ROBIN_EN
    prefer1_s  = (last_winner_r == 1'b0);
`else
    // Last-winner history is tracked but masked: requester 0 always wins.
    prefer1_s  = 1'b0 & last_winner_r;
`endif
    if (rst) begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end else if (collide_s) begin
      req0_ready = !prefer1_s;
      req1_ready = prefer1_s;
    end else begin
      req0_ready = 1'b1;
      req1_ready = 1'b1;
    end
  end

  assign ram_addr_a = req0_addr;
  assign ram_din_a  = req0_wdata;
  assign ram_we_a   = req0_valid && req0_ready && req0_we;
  assign ram_addr_b = req1_addr;
  assign ram_din_b  = req1_wdata;
  assign ram_we_b   = req1_valid && req1_ready && req1_we;

  // Response outputs read as reset values for the whole reset cycle, so an
  // in-flight read cancelled by reset never shows a strobe.
  assign rsp0_valid   = rsp0_valid_r && !rst;
  assign rsp1_valid   = rsp1_valid_r && !rst;
  assign rsp0_rdata   = rst ? {DATA_WIDTH{1'b0}} : (rsp0_valid_r ? ram_dout_a : rdata0_hold_r);
  assign rsp1_rdata   = rst ? {DATA_WIDTH{1'b0}} : (rsp1_valid_r ? ram_dout_b : rdata1_hold_r);
  assign conflict_cnt = rst ? {CNT_WIDTH{1'b0}} : cnt_r;

  // Read-response strobes and last-returned data holding
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid_r  <= 1'b0;
      rsp1_valid_r  <= 1'b0;
      rdata0_hold_r <= {DATA_WIDTH{1'b0}};
      rdata1_hold_r <= {DATA_WIDTH{1'b0}};
    end else begin
      rsp0_valid_r <= req0_valid && req0_ready && !req0_we;
      rsp1_valid_r <= req1_valid && req1_ready && !req1_we;
      if (rsp0_valid_r) begin
        rdata0_hold_r <= ram_dout_a;
      end
      if (rsp1_valid_r) begin
        rdata1_hold_r <= ram_dout_b;
      end
    end
  end

  // Priority history and saturating collision counter
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_r <= 1'b1;
      cnt_r         <= {CNT_WIDTH{1'b0}};
    end else if (collide_s) begin
      last_winner_r <= req1_ready;
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

endmodule
